// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//   Stalls the pipeline during data-memory accesses. It turns a level-held
//   MEM-stage load or store request into a fixed-length access to an external
//   asynchronous SRAM. Each access holds the SRAM strobes for WAIT_CYCLES
//   cycles. While a request is outstanding, ready is held low so the pipeline
//   and PC freeze.
//
// Ports
//   clk         in   1   rising-edge clock
//   rst_n       in   1   asynchronous active-low reset
//   mem_r_en    in   1   load request (held while frozen)
//   mem_w_en    in   1   store request (held while frozen); wins over mem_r_en
//   addr        in   32  byte address; data memory starts at byte 1024
//   wdata       in   32  store data
//   rdata       out  32  last completed load result (registered)
//   ready       out  1   combinational; 0 freezes pipeline registers and PC
//   sram_addr   out  18  SRAM word address (registered)
//   sram_wdata  out  32  SRAM write data (registered)
//   sram_rdata  in   32  SRAM read data
//   sram_we_n   out  1   SRAM write strobe, active-low (registered)
//   sram_oe_n   out  1   SRAM output enable, active-low (registered)
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int WAIT_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic        sram_we_n,
  output logic        sram_oe_n
);

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       op_wr;
  logic       req;
  logic       start;
  logic       last;

  // The data window starts at byte 1024, i.e. word 256. 1024 has no bits
  // below bit 2, so subtracting 256 from the word index gives the same bits
  // [19:2] as a full 32-bit subtraction. Addresses below 1024 wrap.
  function automatic logic [17:0] word_addr(input logic [17:0] byte_word);
    return byte_word - 18'd256;
  endfunction

  // Address bits outside [19:2] do not reach the SRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:20], addr[1:0]};

  assign req  = mem_r_en | mem_w_en;
  assign last = (state == ACCESS) && (cnt == LAST_CNT);

  always_comb begin
    state_nxt = state;
    ready     = 1'b1;
    start     = 1'b0;
    case (state)
      IDLE: begin
        // The freeze starts in the same cycle the request appears.
        ready = ~req;
        if (req) begin
          start     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        ready = 1'b0;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        // The pipeline advances this cycle. A request still held here
        // belongs to the finished instruction, so it must not restart.
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 4'd0;
      op_wr      <= 1'b0;
      rdata      <= 32'd0;
      sram_addr  <= 18'd0;
      sram_wdata <= 32'd0;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
    end else if (start) begin
      // Latch the operation here. Input changes during ACCESS are ignored.
      op_wr      <= mem_w_en;
      sram_addr  <= word_addr(addr[19:2]);
      sram_wdata <= wdata;
      cnt        <= 4'd0;
      sram_we_n  <= ~mem_w_en;
      sram_oe_n  <= mem_w_en;
    end else if (state == ACCESS) begin
      if (last) begin
        cnt       <= 4'd0;
        sram_we_n <= 1'b1;
        sram_oe_n <= 1'b1;
        if (!op_wr) rdata <= sram_rdata;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_we_n;
  logic        sram_oe_n;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_ctrl #(.WAIT_CYCLES(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_r_en   (mem_r_en),
    .mem_w_en   (mem_w_en),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .sram_we_n  (sram_we_n),
    .sram_oe_n  (sram_oe_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request on the next falling edge and follows it until ready
  // returns high (the DONE cycle) or the cycle budget expires. It returns the
  // number of ready-low and strobe-low cycles it saw. The address and write
  // data are scrambled mid-access to show that only latched values are used.
  // The bench stays in the DONE cycle on return. Unless hold is set, the
  // request is released there.
  task automatic run_req(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] srd,
                         input logic hold,
                         output int rdy_low, output int we_low,
                         output int oe_low, output logic done_ok);
    rdy_low = 0; we_low = 0; oe_low = 0; done_ok = 1'b0;
    @(negedge clk);
    mem_r_en = r; mem_w_en = w; addr = a; wdata = wd; sram_rdata = srd;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (sram_we_n === 1'b0) we_low++;
      if (sram_oe_n === 1'b0) oe_low++;
      if (ready === 1'b1) begin
        done_ok = 1'b1;
        break;
      end
      rdy_low++;
      @(negedge clk);
      if (k == 2) begin
        addr  = 32'hFFFF_FFFC;
        wdata = 32'hBAD0_BAD0;
      end
    end
    if (!hold) begin
      mem_r_en = 1'b0;
      mem_w_en = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_r_en = 1'b0; mem_w_en = 1'b0;
    addr = 32'd0; wdata = 32'd0; sram_rdata = 32'd0;
    @(negedge clk);
    #1;
    n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_tests++; if (sram_addr !== 18'd0) begin n_fail++; $display("FAIL reset_sram_addr: got %h want 0", sram_addr); end
    n_tests++; if (sram_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_sram_wdata: got %h want 0", sram_wdata); end
    n_tests++; if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL reset_we_n: got %b want 1", sram_we_n); end
    n_tests++; if (sram_oe_n !== 1'b1) begin n_fail++; $display("FAIL reset_oe_n: got %b want 1", sram_oe_n); end
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b want 1", ready); end
  endtask

  task automatic test_load();
    int rl, wl, ol; logic ok;
    run_req(1'b1, 1'b0, 32'd1028, 32'h0, 32'hDEAD_BEEF, 1'b0, rl, wl, ol, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL load_done: timeout waiting for ready"); end
    n_tests++; if (rl !== 6) begin n_fail++; $display("FAIL load_ready_low: got %0d want 6", rl); end
    n_tests++; if (ol !== 5) begin n_fail++; $display("FAIL load_oe_low: got %0d want 5", ol); end
    n_tests++; if (wl !== 0) begin n_fail++; $display("FAIL load_we_low: got %0d want 0", wl); end
    n_tests++; if (sram_addr !== 18'd1) begin n_fail++; $display("FAIL load_sram_addr: got %h want 1", sram_addr); end
    n_tests++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_rdata: got %h want deadbeef", rdata); end
  endtask

  task automatic test_store();
    int rl, wl, ol; logic ok;
    run_req(1'b0, 1'b1, 32'd1036, 32'h1234_5678, 32'h0, 1'b0, rl, wl, ol, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL store_done: timeout waiting for ready"); end
    n_tests++; if (rl !== 6) begin n_fail++; $display("FAIL store_ready_low: got %0d want 6", rl); end
    n_tests++; if (wl !== 5) begin n_fail++; $display("FAIL store_we_low: got %0d want 5", wl); end
    n_tests++; if (ol !== 0) begin n_fail++; $display("FAIL store_oe_low: got %0d want 0", ol); end
    n_tests++; if (sram_addr !== 18'd3) begin n_fail++; $display("FAIL store_sram_addr: got %h want 3", sram_addr); end
    n_tests++; if (sram_wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL store_sram_wdata: got %h want 12345678", sram_wdata); end
    n_tests++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL store_rdata_kept: got %h want deadbeef", rdata); end
  endtask

  task automatic test_back_to_back();
    int rl, wl, ol; logic ok;
    run_req(1'b0, 1'b1, 32'd1040, 32'hCAFE_F00D, 32'h0, 1'b0, rl, wl, ol, ok);
    n_tests++; if (ok !== 1'b1 || rl !== 6 || wl !== 5) begin n_fail++; $display("FAIL b2b_store: done %b ready_low %0d we_low %0d want 1/6/5", ok, rl, wl); end
    n_tests++; if (sram_addr !== 18'd4 || sram_wdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL b2b_store_bus: got %h/%h want 4/cafef00d", sram_addr, sram_wdata); end
    run_req(1'b1, 1'b0, 32'd1044, 32'h0, 32'h0BAD_F00D, 1'b0, rl, wl, ol, ok);
    n_tests++; if (ok !== 1'b1 || rl !== 6 || ol !== 5) begin n_fail++; $display("FAIL b2b_load: done %b ready_low %0d oe_low %0d want 1/6/5", ok, rl, ol); end
    n_tests++; if (sram_addr !== 18'd5) begin n_fail++; $display("FAIL b2b_load_addr: got %h want 5", sram_addr); end
    n_tests++; if (rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL b2b_load_rdata: got %h want 0badf00d", rdata); end
  endtask

  task automatic test_done_hold();
    int rl, wl, ol; logic ok;
    run_req(1'b1, 1'b0, 32'd1048, 32'h0, 32'h7777_1111, 1'b1, rl, wl, ol, ok);
    n_tests++; if (ok !== 1'b1 || rl !== 6) begin n_fail++; $display("FAIL hold_access: done %b ready_low %0d want 1/6", ok, rl); end
    @(negedge clk);
    mem_r_en = 1'b0;
    #1;
    n_tests++; if (ready !== 1'b1 || sram_oe_n !== 1'b1 || sram_we_n !== 1'b1) begin
      n_fail++; $display("FAIL done_no_restart: ready %b oe_n %b we_n %b want 1/1/1", ready, sram_oe_n, sram_we_n);
    end
    n_tests++; if (rdata !== 32'h7777_1111) begin n_fail++; $display("FAIL hold_rdata: got %h want 77771111", rdata); end
  endtask

  task automatic test_conflict();
    int rl, wl, ol; logic ok;
    run_req(1'b1, 1'b1, 32'd1052, 32'hA5A5_5A5A, 32'hFFFF_0000, 1'b0, rl, wl, ol, ok);
    n_tests++; if (ok !== 1'b1 || rl !== 6) begin n_fail++; $display("FAIL conflict_done: done %b ready_low %0d want 1/6", ok, rl); end
    n_tests++; if (wl !== 5 || ol !== 0) begin n_fail++; $display("FAIL conflict_strobes: we_low %0d oe_low %0d want 5/0", wl, ol); end
    n_tests++; if (sram_wdata !== 32'hA5A5_5A5A || sram_addr !== 18'd7) begin n_fail++; $display("FAIL conflict_bus: got %h/%h want 7/a5a55a5a", sram_addr, sram_wdata); end
    n_tests++; if (rdata !== 32'h7777_1111) begin n_fail++; $display("FAIL conflict_rdata_kept: got %h want 77771111", rdata); end
  endtask

  task automatic test_low_addr_wrap();
    int rl, wl, ol; logic ok;
    run_req(1'b0, 1'b1, 32'd0, 32'h0000_0042, 32'h0, 1'b0, rl, wl, ol, ok);
    n_tests++; if (ok !== 1'b1 || wl !== 5) begin n_fail++; $display("FAIL wrap_done: done %b we_low %0d want 1/5", ok, wl); end
    n_tests++; if (sram_addr !== 18'h3FF00) begin n_fail++; $display("FAIL wrap_addr: got %h want 3ff00", sram_addr); end
  endtask

  task automatic test_mid_reset();
    int rl, wl, ol; logic ok;
    @(negedge clk);
    mem_r_en = 1'b1; mem_w_en = 1'b0; addr = 32'd1032; sram_rdata = 32'h55AA_55AA;
    // Cycles 1..3 are ACCESS with the counter at 0, 1 and 2.
    repeat (3) @(negedge clk);
    #1;
    n_tests++; if (sram_oe_n !== 1'b0 || ready !== 1'b0) begin n_fail++; $display("FAIL midrst_pre: oe_n %b ready %b want 0/0", sram_oe_n, ready); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (sram_oe_n !== 1'b1 || sram_we_n !== 1'b1) begin n_fail++; $display("FAIL midrst_strobes: oe_n %b we_n %b want 1/1", sram_oe_n, sram_we_n); end
    n_tests++; if (rdata !== 32'd0 || sram_addr !== 18'd0) begin n_fail++; $display("FAIL midrst_regs: rdata %h addr %h want 0/0", rdata, sram_addr); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_req(1'b1, 1'b0, 32'd1032, 32'h0, 32'h55AA_55AA, 1'b0, rl, wl, ol, ok);
    n_tests++; if (ok !== 1'b1 || rl !== 6 || ol !== 5) begin n_fail++; $display("FAIL midrst_restart: done %b ready_low %0d oe_low %0d want 1/6/5", ok, rl, ol); end
    n_tests++; if (rdata !== 32'h55AA_55AA || sram_addr !== 18'd2) begin n_fail++; $display("FAIL midrst_result: rdata %h addr %h want 55aa55aa/2", rdata, sram_addr); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_back_to_back();
    test_done_hold();
    test_conflict();
    test_low_addr_wrap();
    test_mid_reset();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter: WAIT_CYCLES, default 5, number of SRAM access cycles per request (legal range 1..15).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: mem_r_en  input  1  MEM-stage load request, level-held by frozen pipeline.
REQ-005 SHALL have port: mem_w_en  input  1  MEM-stage store request, level-held by frozen pipeline.
REQ-006 SHALL have port: addr  input  32  byte address from ALU result.
REQ-007 SHALL have port: wdata  input  32  store data.
REQ-008 SHALL have port: rdata  output  32  registered load result.
REQ-009 SHALL have port: ready  output  1  combinational; 0 freezes all pipeline registers and PC.
REQ-010 SHALL have port: sram_addr  output  18  registered SRAM word address.
REQ-011 SHALL have port: sram_wdata  output  32  registered SRAM write data.
REQ-012 SHALL have port: sram_rdata  input  32  SRAM read data.
REQ-013 SHALL have port: sram_we_n  output  1  registered write strobe, active-low.
REQ-014 SHALL have port: sram_oe_n  output  1  registered output enable, active-low.

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS, DONE plus a cycle counter of 4 bits.
REQ-016 IDLE: request = mem_r_en | mem_w_en; ready = ~request (freeze begins in the same cycle the request appears).
REQ-017 IDLE with request: latch op (write if mem_w_en, else read), sram_addr = (addr - 1024)[19:2], sram_wdata = wdata; counter = 0; next ACCESS.
REQ-018 Both mem_r_en and mem_w_en high in IDLE SHALL be treated as a write; rdata unchanged.
REQ-019 ACCESS: ready = 0; sram_we_n = 0 for write, sram_oe_n = 0 for read, other strobe 1; counter increments each cycle.
REQ-020 ACCESS with counter == WAIT_CYCLES-1: read captures sram_rdata into rdata on that edge; next DONE; strobes return to 1 on the same edge.
REQ-021 Inputs changing during ACCESS SHALL be ignored (latched values used).
REQ-022 DONE: ready = 1 for exactly one cycle; strobes 1; next IDLE unconditionally; a request still asserted in DONE SHALL NOT start a new access.
REQ-023 Latency: request first seen in cycle 0 -> ready low cycles 0..WAIT_CYCLES, high in cycle WAIT_CYCLES+1 (DONE).
REQ-024 Back-to-back requests: new request in the IDLE cycle after DONE SHALL start immediately per REQ-017.
REQ-025 rdata SHALL hold its value until the next completed read.
REQ-026 Address below 1024 SHALL wrap modulo 2^32 before bit selection; no error flag.

Reset
REQ-027 rst_n low SHALL immediately (asynchronously) force state IDLE, counter 0, rdata 0, sram_addr 0, sram_wdata 0, sram_we_n 1, sram_oe_n 1, op read.
REQ-028 Reset asserted mid-ACCESS SHALL abort the access with no rdata update; after release a held request restarts from REQ-017.

Verification (WAIT_CYCLES = 5)
REQ-029 Reset: rst_n low between edges -> all outputs per REQ-027 before next edge; ready = 1 with no request.
REQ-030 Load: mem_r_en=1, addr=1028, sram_rdata=0xDEADBEEF -> sram_addr=1, sram_oe_n low 5 cycles, ready low 6 cycles, rdata=0xDEADBEEF with ready=1 in cycle 6.
REQ-031 Store: mem_w_en=1, addr=1036, wdata=0x12345678 -> sram_addr=3, sram_wdata=0x12345678, sram_we_n low exactly 5 cycles, rdata unchanged.
REQ-032 Back-to-back: store then load on consecutive instructions -> DONE, one IDLE cycle starts the load, total ready-low 6+6 cycles, no lost request.
REQ-033 Mid-access reset: assert rst_n low at ACCESS counter 2 of a read -> strobes 1, rdata 0 immediately; after release with mem_r_en held, full 6-cycle freeze repeats.
REQ-034 Conflict: mem_r_en=mem_w_en=1 -> write performed, sram_oe_n stays 1, rdata unchanged.
